// File: rtl/fib_bin2bcd_if.sv
// Handshake bundle between the Fibonacci block's result and the BCD converter.
interface fib_bin2bcd_if #(
  parameter int N = 20,
  parameter int D = 7
);
  logic           start;
  logic [N-1:0]   bin;
  logic           ready;
  logic           done_tick;
  logic [4*D-1:0] bcd;

  modport master (output start, output bin, input ready, input done_tick, input bcd);
  modport slave  (input start, input bin, output ready, output done_tick, output bcd);
endinterface

// File: rtl/fib_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per cycle.
// The published result register is updated only when a conversion completes.
module fib_bin2bcd #(
  parameter int N = 20,
  parameter int D = 7
) (
  input  logic          clk,
  input  logic          rst,
  fib_bin2bcd_if.slave  bus
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP   = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [N-1:0]   r_sh;
  logic [4*D-1:0] r_dig;
  logic [4*D-1:0] r_res;
  logic [CW-1:0]  r_cnt;
  logic [4*D-1:0] w_adj;
  logic [4*D-1:0] w_shift;
  logic           w_last;

  assign w_last = (r_cnt == CW'(1));

  // Add-3 correction on every digit >= 5, then the one-bit left shift.
  always_comb begin
    w_adj = r_dig;
    for (int unsigned i = 0; i < D; i++) begin
      if (r_dig[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_dig[4*i +: 4] + 4'd3;
    end
    w_shift = {w_adj[4*D-2:0], r_sh[N-1]};
  end

  // State register; synchronous reset returns to idle.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake decode from the state register only.
  always_comb begin
    w_next        = S_IDLE;
    bus.ready     = 1'b0;
    bus.done_tick = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.ready = 1'b1;
        w_next    = bus.start ? S_OP : S_IDLE;
      end
      S_OP:   w_next = w_last ? S_DONE : S_OP;
      S_DONE: begin
        bus.done_tick = 1'b1;
        w_next        = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: load on accepted start, shift in op, publish on the last shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh  <= '0;
      r_dig <= '0;
      r_res <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_sh  <= bus.bin;
            r_dig <= '0;
            r_cnt <= CW'(N);
          end
        end
        S_OP: begin
          r_dig <= w_shift;
          r_sh  <= {r_sh[N-2:0], 1'b0};
          r_cnt <= r_cnt - CW'(1);
          if (w_last) r_res <= w_shift;
        end
        default: ;
      endcase
    end
  end

  assign bus.bcd = r_res;

endmodule

// File: tb/tb_fib_bin2bcd.sv
// Directed bench for fib_bin2bcd with hand-computed BCD results.
module tb_fib_bin2bcd;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   dcnt;

  fib_bin2bcd_if #(.N(20), .D(7)) bus ();

  fib_bin2bcd #(.N(20), .D(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses seen at each rising edge.
  always @(posedge clk) begin
    if (rst) dcnt <= 0;
    else if (bus.done_tick === 1'b1) dcnt <= dcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk({tag, "_ready_timeout"}, 32'(n), 32'd0);
  endtask

  // One full conversion: checks ready drop, latency, result and return to idle.
  task automatic conv(input string tag, input logic [19:0] v, input logic [27:0] exp);
    int n;
    wait_ready(tag);
    bus.bin   = v;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_ready_low"}, 32'(bus.ready), 32'd0);
    n = 1;
    while (bus.done_tick !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd21);
    chk({tag, "_bcd"}, 32'(bus.bcd), 32'(exp));
    @(negedge clk);
    chk({tag, "_ready_back"}, 32'(bus.ready), 32'd1);
    chk({tag, "_done_once"}, 32'(bus.done_tick), 32'd0);
  endtask

  logic [19:0] svec [3];
  logic [27:0] sexp [3];

  initial begin
    int fa, fb, ft, d0, dl;
    total = 0;
    bad   = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_done", 32'(bus.done_tick), 32'd0);
    chk("rst_bcd", 32'(bus.bcd), 32'd0);

    conv("zero", 20'd0, 28'h0000000);
    conv("f20", 20'd6765, 28'h0006765);
    conv("one", 20'd1, 28'h0000001);
    conv("b99999", 20'd99999, 28'h0099999);
    conv("b100000", 20'd100000, 28'h0100000);
    conv("max", 20'd1048575, 28'h1048575);

    // Fibonacci model, i=25
    fa = 0; fb = 1;
    for (int i = 0; i < 25; i++) begin
      ft = fa + fb; fa = fb; fb = ft;
    end
    conv("fib25", 20'(fa), 28'h0075025);

    // Busy: start pulses during op and done are ignored
    wait_ready("busy");
    d0 = dcnt;
    bus.bin   = 20'd6765;
    bus.start = 1'b1;
    @(negedge clk);
    for (int t = 1; t <= 21; t++) begin
      bus.start = t[0];
      bus.bin   = 20'd999;
      if (t == 21) begin
        chk("busy_done", 32'(bus.done_tick), 32'd1);
        bus.start = 1'b1;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("busy_idle", 32'(bus.ready), 32'd1);
    repeat (30) @(negedge clk);
    chk("busy_bcd", 32'(bus.bcd), 32'h0006765);
    chk("busy_dcnt", 32'(dcnt - d0), 32'd1);

    // Streaming: start held high, bin changes every cycle
    svec[0] = 20'd12345;  sexp[0] = 28'h0012345;
    svec[1] = 20'd500000; sexp[1] = 28'h0500000;
    svec[2] = 20'd777;    sexp[2] = 28'h0000777;
    wait_ready("stream");
    for (int t = 0; t < 66; t++) begin
      if (t % 22 == 21) begin
        chk($sformatf("stream%0d_done", t / 22), 32'(bus.done_tick), 32'd1);
        chk($sformatf("stream%0d_bcd", t / 22), 32'(bus.bcd), 32'(sexp[t / 22]));
      end else if (t % 22 == 10) begin
        chk($sformatf("stream%0d_nodone", t / 22), 32'(bus.done_tick), 32'd0);
      end
      bus.start = 1'b1;
      bus.bin   = (t % 22 == 0) ? svec[t / 22] : 20'(t * 13 + 5);
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("stream_end_ready", 32'(bus.ready), 32'd1);

    // Reset during op cycle 10 of 123456
    d0 = dcnt;
    bus.bin   = 20'd123456;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_bcd", 32'(bus.bcd), 32'd0);
    chk("abort_ready", 32'(bus.ready), 32'd1);
    chk("abort_done", 32'(bus.done_tick), 32'd0);
    dl = dcnt;
    repeat (30) @(negedge clk);
    chk("abort_nodone", 32'(dcnt - dl), 32'd0);
    conv("after_abort", 20'd54321, 28'h0054321);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
